// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and widths for the ALU command sequencer
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int RES_W  = 5;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_NOT_A = 2'b10,
    OP_ROR_B = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    CAPT = 2'b10,
    RESP = 2'b11
  } seq_state_e;

  // Only add/sub can leave the 4-bit signed range; the other ops never flag overflow.
  function automatic logic is_arith_op(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - parameterised synchronous FIFO buffering ALU commands
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - issues buffered commands one at a time to the registered ALU
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_opcode,
  input  logic [DATA_W-1:0]       cmd_a,
  input  logic [DATA_W-1:0]       cmd_b,
  input  logic [TAG_W-1:0]        cmd_tag,
  output logic [1:0]              alu_opcode,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [RES_W-1:0]        alu_c,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RES_W-1:0]        rsp_result,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_overflow,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int ENTRY_W = 2 + 2*DATA_W + TAG_W;

  seq_state_e          state;
  logic [TAG_W-1:0]    cur_tag;
  logic [ENTRY_W-1:0]  head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                cmd_push;
  logic [1:0]          head_op;
  logic [DATA_W-1:0]   head_a;
  logic [DATA_W-1:0]   head_b;
  logic [TAG_W-1:0]    head_tag;

  assign cmd_ready = rst_n && !fifo_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  // Pops happen only from IDLE or on the response handshake, keeping one command in flight.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == RESP) && rsp_ready));

  assign {head_op, head_a, head_b, head_tag} = head;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_tag      <= '0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_tag      <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            alu_opcode <= head_op;
            alu_a      <= head_a;
            alu_b      <= head_b;
            cur_tag    <= head_tag;
            state      <= WAIT;
          end
        end
        WAIT: state <= CAPT;
        CAPT: begin
          rsp_result   <= alu_c;
          rsp_tag      <= cur_tag;
          rsp_overflow <= is_arith_op(alu_opcode) && (alu_c[RES_W-1] != alu_c[RES_W-2]);
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (fifo_pop) begin
              alu_opcode <= head_op;
              alu_a      <= head_a;
              alu_b      <= head_b;
              cur_tag    <= head_tag;
              state      <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
